rx_tdm_slot_ctrl: RTL and testbench
===================================

// Module: rx_tdm_slot_ctrl
// PURPOSE
//  Downstream consumer of the TDM calendar walker's registered chanSel. Each
//  clockCore cycle is one TDM slot; it turns the slot owner into a one-cycle
//  grant when that channel is enabled, has data pending and holds a credit.
//  Tracks per-channel credits returned by the egress buffer; unusable slots are
//  dropped, never deferred.
// PARAMETERS
//  WIDTH       5   chanSel width; all-ones = idle slot (walker reset value)
//  NCHAN       24  channels served; chanSel >= NCHAN treated as idle
//  CREDIT_W    4   per-channel credit counter width
//  CREDIT_MAX  8   credits per channel after reset (<= 2**CREDIT_W-1)
// PORTS
//  clockCore   in   1             core clock
//  resetCore   in   1             async reset, active-high
//  chanSel     in   WIDTH         slot owner from calendar walker
//  chanEn      in   NCHAN         per-channel enable (static cfg)
//  chanReq     in   NCHAN         per-channel data pending (level)
//  creditRet   in   NCHAN         one credit returned per set bit per cycle
//  dnReady     in   1             egress can accept a grant this cycle
//  gntValid    out  1             grant issued (registered)
//  gntChan     out  WIDTH         granted channel index (registered)
//  chanGnt     out  NCHAN         one-hot grant, = decode(gntChan) & gntValid
//  creditErr   out  NCHAN         sticky: credit returned while counter at max
//  creditCnt   out  NCHAN*CREDIT_W flat credit counters, ch0 in LSBs
// BEHAVIOUR
//  - Reset: gntValid=0, gntChan={WIDTH{1'b1}}, chanGnt=0, creditErr=0, every
//    credit counter=CREDIT_MAX; stat counters (if built) = 0.
//  - Slot classification, combinational on chanSel, registered next edge:
//    IDLE  : chanSel >= NCHAN, or !chanEn[ch], or !chanReq[ch]
//    NOCRED: eligible but credit[ch]==0
//    MISS  : eligible, credit>0, dnReady=0
//    GRANT : eligible, credit>0, dnReady=1
//  - Latency 1: chanSel sampled at edge N -> gntValid/gntChan/chanGnt valid
//    after edge N+1, for one cycle only. No grant -> gntValid=0, gntChan holds.
//  - No backpressure to walker; non-GRANT slots are lost.
//  - Credit update per channel per cycle: next = cnt - gnt + ret, gnt from
//    the GRANT decision this cycle. Grant and return same channel same cycle
//    -> unchanged. Return with cnt==CREDIT_MAX and no same-cycle grant -> cnt
//    stays CREDIT_MAX, creditErr[ch] set (cleared only by reset).
//  - Grant never issued at credit 0, so counter never underflows.
//  - Credit checked on pre-update value: a return in the same cycle does not
//    make a zero-credit channel eligible until the next slot.
//  - chanEn deassert does not reset credits; in-flight returns still counted.
//  - Reset mid-operation: all state reverts to reset values immediately
//    (async); first grant no earlier than 2nd edge after reset release.
// CONFIGURATION
//  RX_TDM_SLOT_STAT_EN defined: adds outputs statGnt, statIdle, statNoCred,
//    statMiss (each 16 bits): saturating counters of slot classes, +1 per
//    classified slot, hold at 16'hFFFF; input statClr (1 bit) synchronously
//    zeroes all four, clear wins over same-cycle increment.
//  Not defined: those ports and counters absent; grant/credit behaviour
//    identical.
// TESTING
//  1 Reset: hold resetCore=1, chanSel=5'h1F -> gntValid=0, gntChan=5'h1F,
//    all creditCnt=8, creditErr=0.
//  2 Basic: ch3 en+req, dnReady=1, chanSel=3 at edge N -> gntValid=1,
//    chanGnt=24'h000008 after N+1; credit[3]=7.
//  3 Exhaust: ch5 granted 8 slots, no returns -> credit[5]=0, 9th slot of ch5
//    no grant (NOCRED); one creditRet[5] -> next ch5 slot granted.
//  4 Simultaneous: ch2 granted and creditRet[2]=1 same cycle at credit 4 ->
//    stays 4; creditRet[2] at credit 8, no grant -> stays 8, creditErr[2]=1.
//  5 Idle/miss: chanSel=30, then chanSel=1 with chanReq[1]=0, then chanSel=1
//    with req, dnReady=0 -> gntValid=0 all three; credit[1] unchanged.
//  6 STAT_EN build: above sequence -> statGnt/statIdle/statNoCred/statMiss
//    match slot counts; force 70000 idle slots -> statIdle=16'hFFFF; statClr
//    -> all 0.

Source files
------------

// File: rtl/rx_tdm_slot_ctrl.sv
// rx_tdm_slot_ctrl: turns the TDM slot owner into a one-cycle grant gated by enable, request and credit.
// Define RX_TDM_SLOT_STAT_EN to build the saturating slot-class statistics counters and statClr.
module rx_tdm_slot_ctrl #(
    parameter int WIDTH      = 5,
    parameter int NCHAN      = 24,
    parameter int CREDIT_W   = 4,
    parameter int CREDIT_MAX = 8
) (
    input  logic                      clockCore,
    input  logic                      resetCore,
    input  logic [WIDTH-1:0]          chanSel,
    input  logic [NCHAN-1:0]          chanEn,
    input  logic [NCHAN-1:0]          chanReq,
    input  logic [NCHAN-1:0]          creditRet,
    input  logic                      dnReady,
`ifdef RX_TDM_SLOT_STAT_EN
    input  logic                      statClr,
    output logic [15:0]               statGnt,
    output logic [15:0]               statIdle,
    output logic [15:0]               statNoCred,
    output logic [15:0]               statMiss,
`endif
    output logic                      gntValid,
    output logic [WIDTH-1:0]          gntChan,
    output logic [NCHAN-1:0]          chanGnt,
    output logic [NCHAN-1:0]          creditErr,
    output logic [NCHAN*CREDIT_W-1:0] creditCnt
);

    localparam logic [CREDIT_W-1:0] CMAX = CREDIT_W'(CREDIT_MAX);

    // Returns {overflow, next count}; a grant and a return on the same cycle cancel.
    function automatic logic [CREDIT_W:0] credit_next(input logic [CREDIT_W-1:0] cnt,
                                                      input logic gnt, input logic ret);
        logic [CREDIT_W:0] r;
        r = {1'b0, cnt};
        if (gnt && !ret)
            r = {1'b0, cnt - CREDIT_W'(1)};
        else if (ret && !gnt)
            r = (cnt == CMAX) ? {1'b1, cnt} : {1'b0, cnt + CREDIT_W'(1)};
        return r;
    endfunction

    logic [CREDIT_W-1:0] credit   [NCHAN];
    logic [CREDIT_W-1:0] cred_nxt [NCHAN];
    logic [NCHAN-1:0]    err_nxt;
    logic [NCHAN-1:0]    gnt_vec_p0;
    logic                run_p0;
    logic                elig_p0;
    logic                has_cred_p0;
    logic                grant_p0;

    // Stage p0: classify the current slot from chanSel and pre-update credit
    always_comb begin
        elig_p0     = 1'b0;
        has_cred_p0 = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            if (int'(chanSel) == i) begin
                elig_p0     = chanEn[i] & chanReq[i];
                has_cred_p0 = (credit[i] != '0);
            end
        end
        grant_p0 = run_p0 & elig_p0 & has_cred_p0 & dnReady;
        gnt_vec_p0 = '0;
        for (int i = 0; i < NCHAN; i++)
            gnt_vec_p0[i] = grant_p0 && (int'(chanSel) == i);
    end

    always_comb begin
        for (int i = 0; i < NCHAN; i++)
            {err_nxt[i], cred_nxt[i]} = credit_next(credit[i], gnt_vec_p0[i], creditRet[i]);
    end

    // Stage p1: registered grant outputs and credit state
    always_ff @(posedge clockCore or posedge resetCore) begin
        if (resetCore) begin
            run_p0    <= 1'b0;
            gntValid  <= 1'b0;
            gntChan   <= '1;
            chanGnt   <= '0;
            creditErr <= '0;
            for (int i = 0; i < NCHAN; i++)
                credit[i] <= CMAX;
        end else begin
            run_p0    <= 1'b1;
            gntValid  <= grant_p0;
            if (grant_p0)
                gntChan <= chanSel;
            chanGnt   <= gnt_vec_p0;
            creditErr <= creditErr | err_nxt;
            for (int i = 0; i < NCHAN; i++)
                credit[i] <= cred_nxt[i];
        end
    end

    for (genvar g = 0; g < NCHAN; g++) begin : g_flat
        assign creditCnt[g*CREDIT_W +: CREDIT_W] = credit[g];
    end

`ifdef RX_TDM_SLOT_STAT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic hit);
        return (hit && c != 16'hFFFF) ? c + 16'd1 : c;
    endfunction

    logic idle_p0;
    logic nocred_p0;
    logic miss_p0;
    assign idle_p0   = run_p0 & ~elig_p0;
    assign nocred_p0 = run_p0 & elig_p0 & ~has_cred_p0;
    assign miss_p0   = run_p0 & elig_p0 & has_cred_p0 & ~dnReady;

    always_ff @(posedge clockCore or posedge resetCore) begin
        if (resetCore || statClr) begin
            statGnt    <= '0;
            statIdle   <= '0;
            statNoCred <= '0;
            statMiss   <= '0;
        end else begin
            statGnt    <= sat_inc(statGnt, grant_p0);
            statIdle   <= sat_inc(statIdle, idle_p0);
            statNoCred <= sat_inc(statNoCred, nocred_p0);
            statMiss   <= sat_inc(statMiss, miss_p0);
        end
    end
`endif

endmodule

// File: tb/tb_rx_tdm_slot_ctrl.sv
// Directed self-checking bench for rx_tdm_slot_ctrl; stat checks are built when RX_TDM_SLOT_STAT_EN is defined.
module tb_rx_tdm_slot_ctrl;

    localparam int WIDTH = 5;
    localparam int NCHAN = 24;
    localparam int CW    = 4;
    localparam int FW    = NCHAN * CW;

    logic             clockCore = 1'b0;
    logic             resetCore;
    logic [WIDTH-1:0] chanSel;
    logic [NCHAN-1:0] chanEn, chanReq, creditRet;
    logic             dnReady;
    logic             gntValid;
    logic [WIDTH-1:0] gntChan;
    logic [NCHAN-1:0] chanGnt, creditErr;
    logic [FW-1:0]    creditCnt;
`ifdef RX_TDM_SLOT_STAT_EN
    logic             statClr;
    logic [15:0]      statGnt, statIdle, statNoCred, statMiss;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    rx_tdm_slot_ctrl #(.WIDTH(WIDTH), .NCHAN(NCHAN), .CREDIT_W(CW), .CREDIT_MAX(8)) dut (
        .clockCore(clockCore), .resetCore(resetCore), .chanSel(chanSel), .chanEn(chanEn),
        .chanReq(chanReq), .creditRet(creditRet), .dnReady(dnReady),
`ifdef RX_TDM_SLOT_STAT_EN
        .statClr(statClr), .statGnt(statGnt), .statIdle(statIdle),
        .statNoCred(statNoCred), .statMiss(statMiss),
`endif
        .gntValid(gntValid), .gntChan(gntChan), .chanGnt(chanGnt),
        .creditErr(creditErr), .creditCnt(creditCnt)
    );

    always #5 clockCore = ~clockCore;

    task automatic step();
        @(posedge clockCore);
        #1;
    endtask

    function automatic logic [CW-1:0] cred(input int ch);
        return creditCnt[ch*CW +: CW];
    endfunction

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetCore = 1'b1;
        chanSel   = 5'h1F;
        chanEn    = '0;
        chanReq   = '0;
        creditRet = '0;
        dnReady   = 1'b0;
`ifdef RX_TDM_SLOT_STAT_EN
        statClr   = 1'b0;
`endif
        step(); step();
        chk("rst_gntValid", FW'(gntValid), FW'(0));
        chk("rst_gntChan", FW'(gntChan), FW'(5'h1F));
        chk("rst_chanGnt", FW'(chanGnt), FW'(0));
        chk("rst_creditErr", FW'(creditErr), FW'(0));
        chk("rst_creditCnt", creditCnt, {NCHAN{4'd8}});

        resetCore = 1'b0;
        chanEn    = '1;
        step();

        // basic grant on ch3
        chanReq[3] = 1'b1; dnReady = 1'b1; chanSel = 5'd3;
        step();
        chk("basic_gntValid", FW'(gntValid), FW'(1));
        chk("basic_gntChan", FW'(gntChan), FW'(3));
        chk("basic_chanGnt", FW'(chanGnt), FW'(24'h000008));
        chk("basic_cred3", FW'(cred(3)), FW'(7));
        chanSel = 5'h1F;
        step();
        chk("idle_gntValid", FW'(gntValid), FW'(0));
        chk("idle_gntChan_hold", FW'(gntChan), FW'(3));
        chk("idle_chanGnt", FW'(chanGnt), FW'(0));

        // exhaust ch5
        chanReq[5] = 1'b1; chanSel = 5'd5;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("exh_gntValid", FW'(gntValid), FW'(1));
            chk("exh_cred5", FW'(cred(5)), FW'(7 - k));
        end
        step();
        chk("nocred_gntValid", FW'(gntValid), FW'(0));
        chk("nocred_gntChan_hold", FW'(gntChan), FW'(5));
        chk("nocred_cred5", FW'(cred(5)), FW'(0));
        creditRet[5] = 1'b1;
        step();
        chk("ret_preupdate_gntValid", FW'(gntValid), FW'(0));
        chk("ret_cred5", FW'(cred(5)), FW'(1));
        creditRet[5] = 1'b0;
        step();
        chk("regrant_gntValid", FW'(gntValid), FW'(1));
        chk("regrant_chanGnt", FW'(chanGnt), FW'(24'h000020));
        chk("regrant_cred5", FW'(cred(5)), FW'(0));

        // simultaneous grant/return on ch2, then overflow
        chanReq[2] = 1'b1; chanSel = 5'd2;
        for (int k = 0; k < 4; k++) step();
        chk("sim_pre_cred2", FW'(cred(2)), FW'(4));
        creditRet[2] = 1'b1;
        step();
        chk("sim_gntValid", FW'(gntValid), FW'(1));
        chk("sim_cred2", FW'(cred(2)), FW'(4));
        chanSel = 5'h1F;
        for (int k = 0; k < 4; k++) step();
        chk("refill_cred2", FW'(cred(2)), FW'(8));
        chk("refill_creditErr", FW'(creditErr), FW'(0));
        step();
        chk("ovf_cred2", FW'(cred(2)), FW'(8));
        chk("ovf_creditErr", FW'(creditErr), FW'(24'h000004));
        creditRet[2] = 1'b0;
        step();
        chk("ovf_sticky", FW'(creditErr), FW'(24'h000004));

        // idle / miss / disabled on ch1
        chanSel = 5'd30;
        step();
        chk("sel30_gntValid", FW'(gntValid), FW'(0));
        chanSel = 5'd24;
        step();
        chk("sel24_gntValid", FW'(gntValid), FW'(0));
        chanSel = 5'd1;
        step();
        chk("noreq_gntValid", FW'(gntValid), FW'(0));
        chanReq[1] = 1'b1; dnReady = 1'b0;
        step();
        chk("miss_gntValid", FW'(gntValid), FW'(0));
        chanEn[1] = 1'b0; dnReady = 1'b1;
        step();
        chk("dis_gntValid", FW'(gntValid), FW'(0));
        chk("dis_cred1", FW'(cred(1)), FW'(8));
        chanEn[1] = 1'b1;
        step();
        chk("en_gntValid", FW'(gntValid), FW'(1));
        chk("en_cred1", FW'(cred(1)), FW'(7));

`ifdef RX_TDM_SLOT_STAT_EN
        statClr = 1'b1;
        step();
        chk("clr_statGnt", FW'(statGnt), FW'(0));
        statClr = 1'b0;
        chanSel = 5'd30; step();
        chanSel = 5'd24; step();
        chanSel = 5'd5;  step();
        dnReady = 1'b0; chanSel = 5'd1; step();
        dnReady = 1'b1; step();
        step();
        chanSel = 5'h1F;
        chk("stat_gnt", FW'(statGnt), FW'(2));
        chk("stat_idle", FW'(statIdle), FW'(2));
        chk("stat_nocred", FW'(statNoCred), FW'(1));
        chk("stat_miss", FW'(statMiss), FW'(1));
        for (int k = 0; k < 70000; k++) step();
        chk("stat_idle_sat", FW'(statIdle), FW'(16'hFFFF));
        chk("stat_gnt_hold", FW'(statGnt), FW'(2));
        statClr = 1'b1;
        step();
        statClr = 1'b0;
        chk("stat_clr_gnt", FW'(statGnt), FW'(0));
        chk("stat_clr_idle", FW'(statIdle), FW'(0));
        chk("stat_clr_nocred", FW'(statNoCred), FW'(0));
        chk("stat_clr_miss", FW'(statMiss), FW'(0));
`endif

        // asynchronous reset mid-operation
        chanSel = 5'd3;
        step();
        chk("pre_arst_gntValid", FW'(gntValid), FW'(1));
        #2;
        resetCore = 1'b1;
        #1;
        chk("arst_gntValid", FW'(gntValid), FW'(0));
        chk("arst_gntChan", FW'(gntChan), FW'(5'h1F));
        chk("arst_creditCnt", creditCnt, {NCHAN{4'd8}});
        chk("arst_creditErr", FW'(creditErr), FW'(0));
        step();
        resetCore = 1'b0;
        step();
        chk("post_rst_edge1", FW'(gntValid), FW'(0));
        step();
        chk("post_rst_edge2", FW'(gntValid), FW'(1));
        chk("post_rst_cred3", FW'(cred(3)), FW'(7));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
